// File: rtl/sro_update_tracker.sv
// -----------------------------------------------------------------------------
// sro_update_tracker
//
// Datapath responder for the random-order asynchronous (SRO) simulation
// controller. Holds the N_ELEM-bit Boolean network state, the per-round
// "updated" mask and the previous round's final state, and picks the next
// element to visit with a Galois LFSR. External combinational rule logic reads
// cur_state/sel_idx and returns next_val; the controller drives the strobes.
//
// Ports:
//   clk             clock
//   rst             synchronous, active-low reset
//   init_load       load init_state; clears mask and last-state history
//   init_state      initial network state
//   en_rng          advance the LFSR this cycle
//   ld_next_state   write next_val into cur_state[sel_idx]
//   ld_updated      set mask[sel_idx]
//   clr_updated     active-low mask clear
//   ld_last_state   capture cur_state into last_state
//   next_val        new value for element sel_idx
//   sel_idx         selected element (low IDX_W bits of the LFSR)
//   cur_state       current network state
//   is_updated      selected element already updated, or index out of range
//   round_done      every mask bit set
//   is_steady_state cur_state equals the last captured state (history valid)
// -----------------------------------------------------------------------------
module sro_update_tracker #(
  parameter int                N_ELEM = 16,
  parameter int                IDX_W  = 4,
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_load,
  input  logic [N_ELEM-1:0] init_state,
  input  logic              en_rng,
  input  logic              ld_next_state,
  input  logic              ld_updated,
  input  logic              clr_updated,
  input  logic              ld_last_state,
  input  logic              next_val,
  output logic [IDX_W-1:0]  sel_idx,
  output logic [N_ELEM-1:0] cur_state,
  output logic              is_updated,
  output logic              round_done,
  output logic              is_steady_state
);

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form.
  localparam logic [LFSR_W-1:0] POLY = LFSR_W'(16'hB400);

  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_next;
  logic [N_ELEM-1:0] mask;
  logic [N_ELEM-1:0] mask_next;
  logic [N_ELEM-1:0] last_state;
  logic              last_valid;

  logic [N_ELEM-1:0] sel_dec;    // one-hot decode of sel_idx, zero when out of range
  logic [N_ELEM-1:0] wr_dec;     // element written this cycle, if any
  logic              in_range;
  logic              sel_masked;
  logic              wr_en;

  assign sel_idx = lfsr[IDX_W-1:0];

  // Decoding into an N_ELEM-wide one-hot avoids indexing the mask with an
  // index that can exceed N_ELEM-1; out-of-range indices simply decode to 0.
  for (genvar i = 0; i < N_ELEM; i++) begin : g_dec
    assign sel_dec[i] = (sel_idx == IDX_W'(i));
  end

  assign in_range   = |sel_dec;
  assign sel_masked = |(mask & sel_dec);
  assign is_updated = ~in_range | sel_masked;

  // A write needs a live, not-yet-updated selection; init_load takes priority
  // over it in the state register below.
  assign wr_en  = ld_next_state & ~is_updated;
  assign wr_dec = sel_dec & {N_ELEM{wr_en}};

  assign round_done      = &mask;
  assign is_steady_state = last_valid & (cur_state == last_state);

  // NOTE: every variable assigned in a combinational block gets a default at
  // the top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    lfsr_next = lfsr;
    mask_next = mask;
    if (en_rng) begin
      lfsr_next = {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? POLY : '0);
    end
    if (init_load || !clr_updated) begin
      // Clear beats set, so a simultaneous clear and set leaves the mask empty.
      mask_next = '0;
    end else if (ld_updated) begin
      mask_next = mask | sel_dec;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  // The reset is synchronous (sampled only at the clock edge) and every
  // register, including last_state, gets a defined reset value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr       <= SEED;
      cur_state  <= '0;
      mask       <= '0;
      last_state <= '0;
      last_valid <= 1'b0;
    end else begin
      lfsr <= lfsr_next;
      mask <= mask_next;
      if (init_load) begin
        cur_state  <= init_state;
        last_valid <= 1'b0;
      end else begin
        cur_state <= (cur_state & ~wr_dec) | ({N_ELEM{next_val}} & wr_dec);
        if (ld_last_state) begin
          last_state <= cur_state;
          last_valid <= 1'b1;
        end
      end
    end
  end

endmodule
